// File: rtl/display_pkg.sv
// Shared constants and helpers for the 3-bit up/down display counter.
// The helper sizes each button's debounce counter from its hold length.
package display_pkg;

    localparam int COUNT_W                 = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Bits needed to count from 0 up to cycles-1 (at least one bit).
    function automatic int debounce_cnt_w(input int cycles);
        int w;
        w = 1;
        while ((1 << w) < cycles) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/display_3bits_counter_debounce.sv
// One pushbutton path: 2-flop synchronizer, hold-time debounce and a
// registered one-cycle pulse on each accepted press (0->1 of the stable level).
module button_debounce
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted one; any agreement restarts the hold window from zero.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/display_3bits_counter.sv
// 3-bit modulo-8 up/down counter driven by two debounced pushbuttons,
// with synchronous load, enable gating and registered wrap/changed pulses.
module display_3bits_counter
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               enable,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               changed
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_MIN = '0;

    logic               up_press;
    logic               down_press;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               wrap_q;
    logic               wrap_d;
    logic               changed_q;
    logic               changed_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_debounce (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn_up),
        .press_o (up_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_debounce (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn_down),
        .press_o (down_press)
    );

    // Load wins over everything and swallows any coincident press;
    // simultaneous up and down presses cancel each other.
    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        changed_d = 1'b0;
        if (load) begin
            count_d   = load_value;
            changed_d = (load_value != count_q);
        end else if (enable) begin
            if (up_press && !down_press) begin
                count_d   = count_q + 1'b1;
                wrap_d    = (count_q == CNT_MAX);
                changed_d = 1'b1;
            end else if (down_press && !up_press) begin
                count_d   = count_q - 1'b1;
                wrap_d    = (count_q == CNT_MIN);
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wrap_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            changed_q <= changed_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_display_3bits_counter.sv
// Bench for display_3bits_counter: directed scenarios plus random button,
// load and enable traffic, all checked every cycle against a history-based model.
module tb_display_3bits_counter;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       enable;
    logic       load;
    logic [2:0] load_value;
    logic [2:0] count;
    logic       wrap;
    logic       changed;

    int n_tests;
    int n_fail;
    int wrap_cnt;
    int chg_cnt;
    bit chk_on;

    display_3bits_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .wrap       (wrap),
        .changed    (changed)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A press is accepted when the button's synchronized level (raw sample
    // from two edges earlier) has disagreed with the accepted level for the
    // last D edges since the previous acceptance; the count reacts one edge later.
    bit raw_hist [2][8192];
    int t_idx;
    int m_cnt;
    bit m_wrap;
    bit m_chg;
    bit m_stable [2];
    int m_last [2];
    bit m_pulse [2];

    function automatic bit synced(input int b, input int t);
        if (t < 2) return 1'b0;
        return raw_hist[b][t-2];
    endfunction

    function automatic bit accepted(input int b, input int t);
        bit ok;
        ok = (t - m_last[b]) >= D;
        for (int k = 0; k < D; k++)
            if (t - k < 0 || synced(b, t - k) == m_stable[b]) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t_idx  = 0;
            m_cnt  = 0;
            m_wrap = 1'b0;
            m_chg  = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_stable[b] = 1'b0;
                m_last[b]   = -1;
                m_pulse[b]  = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
            m_chg  = 1'b0;
            if (load) begin
                m_chg = (int'(load_value) != m_cnt);
                m_cnt = int'(load_value);
            end else if (enable && m_pulse[0] && !m_pulse[1]) begin
                m_wrap = (m_cnt == 7);
                m_cnt  = (m_cnt + 1) % 8;
                m_chg  = 1'b1;
            end else if (enable && m_pulse[1] && !m_pulse[0]) begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + 7) % 8;
                m_chg  = 1'b1;
            end
            raw_hist[0][t_idx] = btn_up;
            raw_hist[1][t_idx] = btn_down;
            for (int b = 0; b < 2; b++) begin
                m_pulse[b] = 1'b0;
                if (accepted(b, t_idx)) begin
                    m_stable[b] = ~m_stable[b];
                    m_last[b]   = t_idx;
                    m_pulse[b]  = m_stable[b];
                end
            end
            if (t_idx < 8191) t_idx++;
        end
    end

    // Scoreboard: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("count",   8'(count),   8'(m_cnt));
            check("wrap",    8'(wrap),    8'(m_wrap));
            check("changed", 8'(changed), 8'(m_chg));
            if (wrap === 1'b1)    wrap_cnt++;
            if (changed === 1'b1) chg_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] v);
        @(negedge clk);
        load       = 1'b1;
        load_value = v;
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Edges until count leaves 'from'; -1 when it never does within the budget.
    task automatic measure(input logic [2:0] from, output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (count != from) begin
                edges = k;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int e;
    int c0;
    int w0;
    int len;
    int mode;
    bit lu;
    bit ld;

    initial begin
        n_tests = 0;
        n_fail = 0;
        wrap_cnt = 0;
        chg_cnt = 0;
        chk_on = 1'b0;
        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        enable = 1'b1;
        load = 1'b0;
        load_value = 3'd0;

        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count",   8'(count),   8'd0);
        check("rst_wrap",    8'(wrap),    8'd0);
        check("rst_changed", 8'(changed), 8'd0);

        // Button held through reset release, then held 20 cycles.
        rst = 1'b0;
        btn_up = 1'b1;
        c0 = chg_cnt;
        measure(3'd0, e);
        check("lat_up", 8'(e), 8'd7);
        check("cnt_up", 8'(count), 8'd1);
        repeat (13) @(posedge clk);
        #1;
        check("no_repeat", 8'(count), 8'd1);
        check("chg_once", 8'(chg_cnt - c0), 8'd1);
        idle(8);

        // Wrap up from 7, wrap down from 0.
        do_load(3'd7);
        w0 = wrap_cnt;
        @(negedge clk);
        btn_up = 1'b1;
        measure(3'd7, e);
        check("wrap_up_cnt", 8'(count), 8'd0);
        repeat (4) @(posedge clk);
        idle(8);
        check("wrap_up_pulse", 8'(wrap_cnt - w0), 8'd1);
        w0 = wrap_cnt;
        @(negedge clk);
        btn_down = 1'b1;
        measure(3'd0, e);
        check("lat_down", 8'(e), 8'd7);
        check("wrap_dn_cnt", 8'(count), 8'd7);
        repeat (4) @(posedge clk);
        idle(8);
        check("wrap_dn_pulse", 8'(wrap_cnt - w0), 8'd1);

        // Bouncing press, then steady high.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_up = (i % 2 == 0);
        end
        @(negedge clk);
        btn_up = 1'b1;
        measure(3'd7, e);
        check("lat_bounce", 8'(e), 8'd7);
        check("bounce_cnt", 8'(count), 8'd0);
        repeat (10) @(posedge clk);
        #1;
        check("bounce_once", 8'(count), 8'd0);
        idle(8);

        // Both buttons together cancel.
        do_load(3'd3);
        c0 = chg_cnt;
        @(negedge clk);
        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("both_cnt", 8'(count), 8'd3);
        check("both_nochg", 8'(chg_cnt - c0), 8'd0);
        idle(8);

        // Load coincident with the up pulse: press discarded.
        w0 = wrap_cnt;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        load = 1'b1;
        load_value = 3'd5;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("load_win_cnt", 8'(count), 8'd5);
        idle(8);
        check("load_nowrap", 8'(wrap_cnt - w0), 8'd0);

        // Press while disabled, enable raised while still held.
        @(negedge clk);
        enable = 1'b0;
        btn_up = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("enable_cnt", 8'(count), 8'd5);
        idle(8);

        // Reset pulse inside the debounce window.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_cnt", 8'(count), 8'd0);
        measure(3'd0, e);
        check("lat_after_rst", 8'(e), 8'd7);
        check("cnt_after_rst", 8'(count), 8'd1);
        idle(8);

        // Random traffic against the model.
        for (int seg = 0; seg < 120; seg++) begin
            len  = $urandom_range(1, 12);
            mode = $urandom_range(0, 3);
            lu   = 1'($urandom_range(0, 1));
            ld   = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                if (mode == 0) begin
                    btn_up   = 1'($urandom_range(0, 1));
                    btn_down = 1'($urandom_range(0, 1));
                end else begin
                    btn_up   = lu;
                    btn_down = ld;
                end
                load       = ($urandom_range(0, 9) == 0);
                load_value = 3'($urandom_range(0, 7));
                enable     = ($urandom_range(0, 7) != 0);
                rst        = ($urandom_range(0, 149) == 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        enable = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_3bits_counter.md
DISPLAY_3BITS_COUNTER -- requirements
Module: display_3bits_counter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive synchronized cycles a button level must hold before it is accepted (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn_up  input  1  raw pushbutton, asynchronous to clk and may bounce; a press increments the count.
REQ-005 btn_down  input  1  raw pushbutton, asynchronous to clk and may bounce; a press decrements the count.
REQ-006 enable  input  1  synchronous; when low, accepted presses are discarded.
REQ-007 load  input  1  synchronous; when high, writes load_value into the count.
REQ-008 load_value  input  3  value written on load.
REQ-009 count  output  3  registered current value, wired directly to the 3-bit 7-segment decoder inputs.
REQ-010 wrap  output  1  one-cycle pulse on a count step 7->0 or 0->7.
REQ-011 changed  output  1  one-cycle pulse in the cycle after any change of count by step or load.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce, per button:
- Counter resets to 0 whenever synced level == stable level.
- Counter increments while synced level differs from stable level.
- When the counter reaches DEBOUNCE_CYCLES-1 with the level still different, stable takes the synced level and the counter clears.
REQ-014 A press pulse SHALL be asserted for exactly one cycle on each 0->1 transition of stable; a 1->0 transition produces no pulse.
REQ-015 Latency: with the raw input held high, count SHALL change on rising edge DEBOUNCE_CYCLES+3, counted from the first edge that samples it high.
REQ-016 A raw high lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse.
REQ-017 Count update priority, evaluated each cycle:
- load: count = load_value.
- else, enable low: count holds.
- else, up pulse only: count+1 mod 8.
- else, down pulse only: count-1 mod 8.
- else, up and down pulses in the same cycle: count holds, with no wrap and no changed pulse.
REQ-018 A press pulse that coincides with load SHALL be discarded, not deferred.
REQ-019 wrap SHALL assert only for steps, never for load.
REQ-020 changed SHALL assert for a load only if load_value differs from the previous count.
REQ-021 A held button SHALL produce a single step; there is no auto-repeat.
REQ-022 The count arithmetic SHALL be 3-bit unsigned modulo 8, with no saturation.

Reset
REQ-023 While rst is high, on each rising edge, count, wrap, changed, all synchronizer flops, debounce counters and stable levels SHALL be cleared to 0.
REQ-024 Reset asserted mid-debounce SHALL discard the pending press.
REQ-025 A button held through reset release SHALL be counted once, after the full REQ-015 latency measured from the first post-reset edge.
REQ-026 Outputs SHALL be valid (count = 0, pulses low) from the first edge with rst high.

Structure
REQ-027 A shared package display_pkg SHALL hold:
- COUNT_W = 3;
- DEBOUNCE_CYCLES_DEFAULT = 4;
- the debounce-counter width function.
REQ-028 One sub-module, button_debounce, SHALL contain the synchronizer, debounce and rise-pulse logic; it is instantiated twice.
REQ-029 The top level SHALL hold only the count register and the wrap and changed logic.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Reset, then btn_up held high for 20 cycles -> count goes 0->1 on edge 7 after first sample; changed pulses once; no further steps while held.
REQ-031 count = 7, one clean btn_up press -> count = 0, wrap = 1 for one cycle; from 0, one btn_down press -> count = 7, wrap pulses.
REQ-032 btn_up bouncing 1,0,1,0 every cycle for 10 cycles, then held high -> exactly one increment, occurring 7 edges after the steady-high start.
REQ-033 Both buttons pressed on the same cycle, count = 3 -> count stays 3, no changed pulse; load = 1 with load_value = 5 coincident with an up pulse -> count = 5, wrap = 0.
REQ-034 enable = 0 during a btn_up press -> count unchanged; raising enable afterward while still held -> still no step.
REQ-035 rst asserted for 1 cycle during the debounce window of a btn_up press -> count = 0, and no increment until a fresh full latency from the first post-reset edge.
